// File: rtl/key_event_module_pkg.sv
// Shared definitions for the key event classifier: timing defaults,
// counter width, FSM state encodings and the internal event codes.
package key_event_module_pkg;

  localparam logic [15:0] T1MS_DEFAULT = 16'd49_999;
  localparam int          MS_W         = 12;
  localparam logic [MS_W-1:0] MS_MAX   = '1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HELD   = 3'd2,
    WAIT2  = 3'd3,
    PRESS2 = 3'd4
  } key_state_e;

  typedef enum logic [2:0] {
    EV_NONE   = 3'd0,
    EV_CLICK  = 3'd1,
    EV_DOUBLE = 3'd2,
    EV_LONG   = 3'd3,
    EV_REPEAT = 3'd4
  } key_event_e;

endpackage

// File: rtl/key_event_module_ms_tick_gen.sv
// Millisecond time base: a prescaler that wraps every T1MS+1 clocks and a
// saturating millisecond counter. A synchronous clear restarts both so a
// caller can time intervals from an arbitrary cycle.
module key_event_module_ms_tick_gen
  import key_event_module_pkg::*;
#(
  parameter logic [15:0] T1MS = T1MS_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clear,
  output logic [MS_W-1:0] ms_cnt
);

  logic [15:0] prescaler;
  logic        ms_tick;

  assign ms_tick = (prescaler == T1MS);

  // Prescaler wraps into a tick; the ms counter advances on ticks and sticks at its maximum
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (clear) begin
      prescaler <= '0;
      ms_cnt    <= '0;
    end else if (ms_tick) begin
      prescaler <= '0;
      if (ms_cnt != MS_MAX) begin
        ms_cnt <= ms_cnt + 1'b1;
      end
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

endmodule

// File: rtl/key_event_module.sv
// Key gesture classifier: turns a debounced key level into one-cycle
// click / double-click / long-press / auto-repeat pulses, plus a busy flag.
module key_event_module
  import key_event_module_pkg::*;
#(
  parameter logic [15:0]     T1MS      = T1MS_DEFAULT,
  parameter logic [MS_W-1:0] LONG_MS   = 12'd1000,
  parameter logic [MS_W-1:0] REPEAT_MS = 12'd200,
  parameter logic [MS_W-1:0] DCLICK_MS = 12'd300
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic Pin_In,
  output logic Click_Pulse,
  output logic Double_Pulse,
  output logic Long_Pulse,
  output logic Repeat_Pulse,
  output logic Key_Busy
);

  logic            key_r;
  logic            rise;
  logic            fall;
  logic            restart;
  logic            clear;
  logic [MS_W-1:0] ms_cnt;
  key_state_e      state;
  key_state_e      next_state;
  key_event_e      evt_d;

  // Previous key level; cleared by reset so a key held through reset reads as a new press
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      key_r <= 1'b0;
    end else begin
      key_r <= Pin_In;
    end
  end

  assign rise = Pin_In & ~key_r;
  assign fall = ~Pin_In & key_r;

  // Interval timing restarts on every state change and on each repeat period
  assign clear = restart || (next_state != state);

  key_event_module_ms_tick_gen #(
    .T1MS (T1MS)
  ) u_ms_tick_gen (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (clear),
    .ms_cnt (ms_cnt)
  );

  // Gesture decision: key edges take priority over timer expiry in every state
  always_comb begin
    next_state = state;
    evt_d      = EV_NONE;
    restart    = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          next_state = PRESS1;
        end
      end
      PRESS1: begin
        if (fall) begin
          next_state = WAIT2;
        end else if (ms_cnt == LONG_MS) begin
          next_state = HELD;
          evt_d      = EV_LONG;
        end
      end
      HELD: begin
        if (fall) begin
          next_state = IDLE;
        end else if (ms_cnt == REPEAT_MS) begin
          evt_d   = EV_REPEAT;
          restart = 1'b1;
        end
      end
      WAIT2: begin
        if (rise) begin
          next_state = PRESS2;
          evt_d      = EV_DOUBLE;
        end else if (ms_cnt == DCLICK_MS) begin
          next_state = IDLE;
          evt_d      = EV_CLICK;
        end
      end
      PRESS2: begin
        if (fall) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State register and registered one-hot event pulses, so at most one pulse per cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      Click_Pulse  <= 1'b0;
      Double_Pulse <= 1'b0;
      Long_Pulse   <= 1'b0;
      Repeat_Pulse <= 1'b0;
      Key_Busy     <= 1'b0;
    end else begin
      state        <= next_state;
      Click_Pulse  <= (evt_d == EV_CLICK);
      Double_Pulse <= (evt_d == EV_DOUBLE);
      Long_Pulse   <= (evt_d == EV_LONG);
      Repeat_Pulse <= (evt_d == EV_REPEAT);
      Key_Busy     <= (next_state != IDLE);
    end
  end

endmodule
